// File: rtl/i2s_mic_rx_pkg.sv
// Shared defaults and types for the I2S microphone receiver and related audio blocks.
package i2s_mic_pkg;

  localparam int unsigned SCK_HALF_DIV_DEF = 4;
  localparam int unsigned SLOT_BITS_DEF    = 32;
  localparam int unsigned DATA_WIDTH_DEF   = 16;

  typedef logic [DATA_WIDTH_DEF-1:0] sample_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/i2s_mic_rx_ws_edge_detect.sv
// Registers a 1-bit level and emits one-cycle rise/fall pulses in the cycle after it changes.
// Latency: pulse is combinational from the input against its one-cycle-old copy; no backpressure.
module ws_edge_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver: generates sck/ws from CLK and deserialises left/right samples from sd.
// Samples are published at slot end, valid in the ws_rise/ws_fall pulse cycle; no backpressure.
module i2s_mic_rx
  import i2s_mic_pkg::*;
#(
  parameter int unsigned SCK_HALF_DIV = SCK_HALF_DIV_DEF,
  parameter int unsigned SLOT_BITS    = SLOT_BITS_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  sd,
  output logic                  sck,
  output logic                  ws,
  output logic [DATA_WIDTH-1:0] data_left,
  output logic [DATA_WIDTH-1:0] data_right,
  output logic                  ws_rise,
  output logic                  ws_fall,
  output logic                  irq
);

  localparam int unsigned DIV_W = cnt_width(SCK_HALF_DIV);
  localparam int unsigned BIT_W = cnt_width(SLOT_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCK_HALF_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] SLOT_LAST = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] MSB_POS   = BIT_W'(1);
  localparam logic [BIT_W-1:0] LSB_POS   = BIT_W'(DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  sck_q, sck_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  ws_q, ws_d;
  logic                  sd_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic [DATA_WIDTH-1:0] shift_in;

  logic div_term;
  logic rise_stb;
  logic fall_stb;
  logic slot_end;
  logic in_data_window;

  generate
    if (DATA_WIDTH == 1) begin : g_shift_1b
      assign shift_in = sd_q;
    end else begin : g_shift_nb
      assign shift_in = {shift_q[DATA_WIDTH-2:0], sd_q};
    end
  endgenerate

  always_comb begin
    div_term       = (div_cnt_q == DIV_LAST);
    rise_stb       = div_term & ~sck_q;
    fall_stb       = div_term &  sck_q;
    slot_end       = fall_stb & (bit_cnt_q == SLOT_LAST);
    in_data_window = (bit_cnt_q >= MSB_POS) && (bit_cnt_q <= LSB_POS);

    div_cnt_d = div_term ? '0 : div_cnt_q + DIV_ONE;
    sck_d     = sck_q ^ div_term;

    bit_cnt_d = bit_cnt_q;
    ws_d      = ws_q;
    if (fall_stb) begin
      if (bit_cnt_q == SLOT_LAST) begin
        bit_cnt_d = '0;
        ws_d      = ~ws_q;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_ONE;
      end
    end

    // One-bit I2S delay: slot bit 0 is skipped, bit 1 carries the MSB.
    shift_d = shift_q;
    left_d  = left_q;
    right_d = right_q;
    if (rise_stb && in_data_window) begin
      shift_d = shift_in;
    end
    if (slot_end) begin
      if (!ws_q) begin
        left_d = shift_q;
      end else begin
        right_d = shift_q;
      end
      shift_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      bit_cnt_q <= '0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
      shift_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      bit_cnt_q <= bit_cnt_d;
      ws_q      <= ws_d;
      sd_q      <= sd;
      shift_q   <= shift_d;
      left_q    <= left_d;
      right_q   <= right_d;
    end
  end

  ws_edge_detect u_ws_edge (
    .clk_i   (CLK),
    .rst_n_i (RESET_N),
    .sig_i   (ws_q),
    .rise_o  (ws_rise),
    .fall_o  (ws_fall)
  );

  assign sck        = sck_q;
  assign ws         = ws_q;
  assign data_left  = left_q;
  assign data_right = right_q;
  assign irq        = ws_rise | ws_fall;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Scoreboard bench: drivers push expected samples as each slot starts, monitors pop on ws pulses.
module tb_i2s_mic_rx;
  import i2s_mic_pkg::*;

  localparam int SLOT = 32;
  localparam int DW   = 16;
  localparam int DW2  = 24;
  localparam int NF   = 6;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            sd = 1'b1;
  logic            sck, ws, ws_rise, ws_fall, irq;
  sample_t         data_left, data_right;

  logic            rst2_n = 1'b0;
  logic            sd2 = 1'b1;
  logic            sck2, ws2, rise2, fall2, irq2;
  logic [DW2-1:0]  dl2, dr2;

  i2s_mic_rx dut (
    .CLK(CLK), .RESET_N(RESET_N), .sd(sd), .sck(sck), .ws(ws),
    .data_left(data_left), .data_right(data_right),
    .ws_rise(ws_rise), .ws_fall(ws_fall), .irq(irq)
  );

  i2s_mic_rx #(.SCK_HALF_DIV(2), .SLOT_BITS(32), .DATA_WIDTH(DW2)) dut2 (
    .CLK(CLK), .RESET_N(rst2_n), .sd(sd2), .sck(sck2), .ws(ws2),
    .data_left(dl2), .data_right(dr2),
    .ws_rise(rise2), .ws_fall(fall2), .irq(irq2)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  sample_t left_tab  [NF] = '{16'hA5C3, 16'hFFFF, 16'h0000, 16'hA5C3, 16'h5A3C, 16'h1357};
  sample_t right_tab [NF] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 16'h0F0F, 16'h9BDF};
  logic [DW2-1:0] left2  = 24'h800001;
  logic [DW2-1:0] right2 = 24'h7FFFFE;

  sample_t        exp_l[$], exp_r[$];
  logic [DW2-1:0] exp2_l[$], exp2_r[$];

  int drv_cnt = 0, drv_side = 0, drv_frame = 0;
  bit drv_started = 0;
  bit done2 = 0;

  // Driver for the default instance: tracks slot position on each sck falling edge.
  initial begin
    sample_t w;
    forever begin
      @(negedge sck or negedge RESET_N);
      if (!RESET_N) begin
        if (drv_started) drv_frame++;
        drv_started = 0;
        drv_cnt = 0;
        drv_side = 0;
        sd = 1'b1;
      end else begin
        drv_started = 1;
        if (drv_cnt == SLOT - 1) begin
          drv_cnt = 0;
          drv_side ^= 1;
          if (drv_side == 0) drv_frame++;
        end else begin
          drv_cnt++;
        end
        w = drv_side ? right_tab[drv_frame % NF] : left_tab[drv_frame % NF];
        if (drv_cnt == 1) begin
          if (drv_side == 0) exp_l.push_back(w);
          else exp_r.push_back(w);
        end
        sd = (drv_cnt >= 1 && drv_cnt <= DW) ? w[DW - drv_cnt] : 1'b1;
      end
    end
  end

  // Driver for the 24-bit / fast-sck instance.
  initial begin
    int c2, s2;
    logic [DW2-1:0] w2;
    c2 = 0;
    s2 = 0;
    forever begin
      @(negedge sck2);
      if (c2 == SLOT - 1) begin
        c2 = 0;
        s2 ^= 1;
      end else begin
        c2++;
      end
      w2 = s2 ? right2 : left2;
      if (c2 == 1) begin
        if (s2 == 0) exp2_l.push_back(w2);
        else exp2_r.push_back(w2);
      end
      sd2 = (c2 >= 1 && c2 <= DW2) ? w2[DW2 - c2] : 1'b1;
    end
  end

  // Monitor for the default instance.
  initial begin
    int last_rise;
    logic irq_prev;
    last_rise = -1;
    irq_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET_N) begin
        check("irq_is_or", {31'b0, irq}, {31'b0, ws_rise | ws_fall});
        if (irq) check("irq_single_cycle", {31'b0, irq_prev}, 32'd0);
        if (ws_rise) begin
          if (exp_l.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ws_rise: data_left=0x%0h, no sample expected", data_left);
          end else begin
            check("data_left", {16'b0, data_left}, {16'b0, exp_l.pop_front()});
          end
          last_rise = cyc;
        end
        if (ws_fall) begin
          if (exp_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ws_fall: data_right=0x%0h, no sample expected", data_right);
          end else begin
            check("data_right", {16'b0, data_right}, {16'b0, exp_r.pop_front()});
          end
          if (last_rise >= 0) check("rise_to_fall_clks", cyc - last_rise, 32'd256);
        end
        irq_prev = irq;
      end else begin
        irq_prev = 1'b0;
        last_rise = -1;
      end
    end
  end

  // Monitor for the 24-bit instance.
  initial begin
    forever begin
      @(negedge CLK);
      if (rst2_n && rise2) begin
        if (exp2_l.size() == 0) begin
          checks++; errors++;
          $display("FAIL v2_unexpected_rise: dl2=0x%0h", dl2);
        end else check("v2_data_left", {8'b0, dl2}, {8'b0, exp2_l.pop_front()});
      end
      if (rst2_n && fall2) begin
        if (exp2_r.size() == 0) begin
          checks++; errors++;
          $display("FAIL v2_unexpected_fall: dr2=0x%0h", dr2);
        end else check("v2_data_right", {8'b0, dr2}, {8'b0, exp2_r.pop_front()});
      end
    end
  end

  task automatic measure_half(input string name, input bit second, input int exp);
    logic prev;
    int n;
    prev = second ? sck2 : sck;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (((second ? sck2 : sck) == prev) && n < 40);
    check(name, n, exp);
  endtask

  task automatic wait_first_rise(input string name, input int c0);
    int n;
    n = 0;
    while (!ws_rise && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check(name, cyc - c0, 32'd256);
  endtask

  // Parameter variant: sck period 4 CLK, slot 128 CLK.
  initial begin
    int c0, n;
    repeat (5) @(negedge CLK);
    check("v2_rst_sck", {31'b0, sck2}, 32'd0);
    check("v2_rst_dl", {8'b0, dl2}, 32'd0);
    rst2_n = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) measure_half("v2_sck_half", 1'b1, 2);
    n = 0;
    while (!rise2 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check("v2_first_rise_clks", cyc - c0, 32'd128);
    repeat (300) @(negedge CLK);
    done2 = 1;
  end

  initial begin
    int c0, n, falls;
    bit hit;
    repeat (5) @(negedge CLK);
    check("rst_sck", {31'b0, sck}, 32'd0);
    check("rst_ws", {31'b0, ws}, 32'd0);
    check("rst_data_left", {16'b0, data_left}, 32'd0);
    check("rst_data_right", {16'b0, data_right}, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);

    RESET_N = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 4; i++) measure_half("sck_half", 1'b0, 4);
    wait_first_rise("first_rise_clks", c0);

    // Interrupt a right slot of frame 3 at slot bit 10.
    hit = 0;
    n = 0;
    while (!hit && n < 5000) begin
      @(negedge CLK);
      n++;
      hit = (drv_frame == 3 && drv_side == 1 && drv_cnt == 10);
    end
    check("reach_mid_right_slot", {31'b0, hit}, 32'd1);
    check("mid_ws_before_reset", {31'b0, ws}, 32'd1);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_sck", {31'b0, sck}, 32'd0);
    check("mid_rst_ws", {31'b0, ws}, 32'd0);
    check("mid_rst_data_left", {16'b0, data_left}, 32'd0);
    check("mid_rst_data_right", {16'b0, data_right}, 32'd0);
    check("mid_rst_irq", {31'b0, irq}, 32'd0);
    exp_l.delete();
    exp_r.delete();
    repeat (5) @(negedge CLK);
    RESET_N = 1'b1;
    c0 = cyc;
    wait_first_rise("post_rst_first_rise_clks", c0);

    falls = 0;
    n = 0;
    while (falls < 2 && n < 3000) begin
      @(negedge CLK);
      n++;
      if (ws_fall) falls++;
    end
    check("post_rst_frames_seen", falls, 32'd2);

    n = 0;
    while (!done2 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("v2_done", {31'b0, done2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/i2s_mic_rx.md
Name: i2s_mic_rx

Overview:
- I2S master receiver for one MEMS microphone data line.
- Generates the bit clock (sck) and word select (ws) from the system clock, and deserialises left/right samples.
- Flags each ws edge with single-cycle pulses, which the Avalon wrapper ORs into its interrupt.
- Sits between the GPIO mic pins and the Avalon-MM mic register block / codec stream mux.

Parameters:
- SCK_HALF_DIV, 4: CLK cycles per sck half-period; legal range >= 2. SCK period = 2*SCK_HALF_DIV CLK.
- SLOT_BITS, 32: sck periods per channel slot; one frame = 2*SLOT_BITS sck periods.
- DATA_WIDTH, 16: captured sample width; legal range 1..SLOT_BITS-1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- sd  input  1  serial data from microphone (GPIO_DIN).
- sck  output  1  I2S bit clock to microphone, registered.
- ws  output  1  I2S word select, registered; 0 = left slot, 1 = right slot.
- data_left  output  DATA_WIDTH  last complete left sample.
- data_right  output  DATA_WIDTH  last complete right sample.
- ws_rise  output  1  one-CLK pulse on ws 0->1 (left sample updated).
- ws_fall  output  1  one-CLK pulse on ws 1->0 (right sample updated, frame complete).
- irq  output  1  ws_rise | ws_fall.

Behaviour:
- Reset (async assert, sync release): div_cnt=0, sck=0, bit_cnt=0, ws=0, sd_q=0, shift=0, data_left=0, data_right=0, ws_d=0. All pulses are 0 during reset.
- sd is registered once into sd_q every CLK.
- Divider:
  - div_cnt counts 0..SCK_HALF_DIV-1; at terminal count it wraps to 0 and sck toggles.
  - rise_stb is asserted in the cycle where div_cnt is terminal and sck=0; fall_stb is the same with sck=1.
- Bit counter:
  - On fall_stb, bit_cnt increments; at bit_cnt==SLOT_BITS-1 it wraps to 0 and ws toggles in the same cycle.
  - ws therefore changes exactly on an sck falling edge.
- Sampling, I2S one-bit delay:
  - On rise_stb with 1 <= bit_cnt <= DATA_WIDTH: shift <= {shift[DATA_WIDTH-2:0], sd_q}. MSB first; bit_cnt 1 is the MSB.
  - Bits at bit_cnt 0 and above DATA_WIDTH are ignored.
- Latching, on fall_stb with bit_cnt==SLOT_BITS-1 (slot end):
  - If ws==0, data_left <= shift; else data_right <= shift.
  - shift clears to 0 in that cycle.
- Edge detect:
  - ws_d <= ws every CLK.
  - ws_rise = ws & ~ws_d; ws_fall = ~ws & ws_d. Each is high for exactly the one CLK cycle after ws toggles.
  - data_left / data_right are already valid in that pulse cycle.
- Timing at defaults: sck period 8 CLK, slot 256 CLK, frame 512 CLK. First ws rise occurs at the 32nd sck falling edge after reset release.
- Outputs hold between updates. There are no simultaneous-event conflicts: latch and sample never share a cycle, because rise_stb and fall_stb are mutually exclusive.
- Reset mid-frame: all state returns to reset values immediately, the partial slot is discarded, and the next frame restarts as a left slot.

Decomposition:
- Package i2s_mic_pkg: default constants SCK_HALF_DIV_DEF=4, SLOT_BITS_DEF=32, DATA_WIDTH_DEF=16, and the typedef sample_t = logic [DATA_WIDTH_DEF-1:0].
- One sub-module, ws_edge_detect: registers its 1-bit input and emits the rising/falling pulses. Reusable by other audio blocks.

Test Plan:
- Reset and clock check: hold RESET_N=0 for 5 CLK -> sck=0, ws=0, data_left=data_right=0, irq=0. After release, sck toggles every 4 CLK and ws toggles every 256 CLK.
- Sample capture: bench drives sd on sck falling edges with left 0xA5C3 and right 0x1234, MSB in bit 1, don't-care bits set to 1 -> at ws_rise data_left=0xA5C3; at ws_fall data_right=0x1234.
- Edge pulses: count CLK cycles -> ws_rise and ws_fall are each high exactly 1 cycle, 256 CLK apart. irq pulses twice per 512-CLK frame and is never high 2 cycles running.
- All-ones then all-zeros frames: left=0xFFFF, right=0x0000, then swapped -> outputs follow per slot with no bit leakage across slots.
- Reset mid-frame: assert RESET_N=0 at bit_cnt=10 of a right slot -> outputs clear asynchronously (before the next CLK). After release, the first ws_rise arrives 256 CLK later with a fresh left sample.
- Parameter variant: SCK_HALF_DIV=2, DATA_WIDTH=24 with left 0x800001 -> sck period 4 CLK, data_left=0x800001.
